// File: rtl/box2x2_filter.sv
// box2x2_filter
//   Streaming 2x2 box-filter stage placed directly after the line buffer.
//   Each in_wen beat forms the window {cur_q, lb_q, in_data, lb_rdata}
//   (previous and current column of the current and previous row) and,
//   when the window is complete and spatially valid, emits its mean.
//
//   Build option: define BOX2X2_FILTER_ROUND_EN for round-half-up averaging
//   ((sum + 2) >> 2). Without it the mean is truncated (sum >> 2).
//
// Parameters
//   WIDTH : pixels per line, equal to the line buffer delay depth (>= 2)
//   DW    : pixel data width
//
// Ports
//   CLK       in   clock, rising edge
//   RESETN    in   asynchronous active-low reset
//   in_data   in   current-row pixel (also written to the line buffer)
//   in_wen    in   in_data valid; advances the stream
//   lb_rdata  in   previous-row pixel, aligned with in_data
//   lb_valid  in   lb_rdata meaningful this cycle
//   out_data  out  filtered pixel (registered)
//   out_valid out  one-cycle pulse when out_data was updated by a window
//   out_col   out  column index of the window's right-hand pixel

module box2x2_filter #(
  parameter int WIDTH = 8,
  parameter int DW    = 16
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_wen,
  input  logic [DW-1:0]            lb_rdata,
  input  logic                     lb_valid,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  output logic [$clog2(WIDTH)-1:0] out_col
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] col_q, col_d;
  logic [DW-1:0] cur_q, cur_d;
  logic [DW-1:0] lb_q, lb_d;
  logic          lbv_q, lbv_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_col_q, out_col_d;

  logic [DW+1:0] sum;
  logic [DW+1:0] mean;
  logic          fire;

  // Four DW-bit operands fit in DW+2 bits, so no overflow is possible.
  assign sum = {2'b00, cur_q} + {2'b00, lb_q} + {2'b00, in_data} + {2'b00, lb_rdata};

`ifdef BOX2X2_FILTER_ROUND_EN
  // Max 4*(2^DW-1)+2 still fits in DW+2 bits, so the +2 never wraps.
  assign mean = (sum + (DW+2)'(2)) >> 2;
`else
  assign mean = sum >> 2;
`endif

  // Column 0 is excluded: the held column then belongs to the previous line.
  assign fire = in_wen & lb_valid & lbv_q & (col_q != '0);

  always_comb begin
    col_d       = col_q;
    cur_d       = cur_q;
    lb_d        = lb_q;
    lbv_d       = lbv_q;
    out_data_d  = out_data_q;
    out_col_d   = out_col_q;
    out_valid_d = 1'b0;
    if (in_wen) begin
      cur_d = in_data;
      lb_d  = lb_rdata;
      lbv_d = lb_valid;
      col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
      if (fire) begin
        out_data_d  = mean[DW-1:0];
        out_col_d   = col_q;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      col_q       <= '0;
      cur_q       <= '0;
      lb_q        <= '0;
      lbv_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
    end else begin
      col_q       <= col_d;
      cur_q       <= cur_d;
      lb_q        <= lb_d;
      lbv_q       <= lbv_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;

endmodule

// File: tb/tb_box2x2_filter.sv
// Directed testbench for box2x2_filter (WIDTH=8, DW=16).
// Expected results follow BOX2X2_FILTER_ROUND_EN when it is defined.

module tb_box2x2_filter;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [15:0] in_data;
  logic        in_wen;
  logic [15:0] lb_rdata;
  logic        lb_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic [2:0]  out_col;

  int num_checks = 0;
  int num_fails  = 0;

  // Expectation state: column counter, captured lb_valid, held outputs
  int unsigned col_m;
  logic        lbv_m;
  logic [15:0] exp_data;
  logic [2:0]  exp_col;

`ifdef BOX2X2_FILTER_ROUND_EN
  localparam logic [15:0] EXP9  = 16'd5;   // (18+2)>>2
  localparam logic [15:0] EXP17 = 16'd13;  // (50+2)>>2
  localparam logic [15:0] EXP21 = 16'd17;  // (66+2)>>2
`else
  localparam logic [15:0] EXP9  = 16'd4;   // 18>>2
  localparam logic [15:0] EXP17 = 16'd12;  // 50>>2
  localparam logic [15:0] EXP21 = 16'd16;  // 66>>2
`endif

  box2x2_filter #(.WIDTH(8), .DW(16)) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .in_data  (in_data),
    .in_wen   (in_wen),
    .lb_rdata (lb_rdata),
    .lb_valid (lb_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_col  (out_col)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; win is the expected mean if this beat fires.
  task automatic beat(input logic wen, input logic [15:0] d, input logic lbv,
                      input logic [15:0] lbd, input logic [15:0] win);
    logic fire;
    @(negedge CLK);
    in_wen   = wen;
    in_data  = d;
    lb_valid = lbv;
    lb_rdata = lbd;
    fire = wen && lbv && lbv_m && (col_m != 0);
    if (fire) begin
      exp_data = win;
      exp_col  = 3'(col_m);
    end
    if (wen) begin
      lbv_m = lbv;
      col_m = (col_m == 7) ? 0 : col_m + 1;
    end
    @(posedge CLK);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, fire});
    check("out_data", {16'd0, out_data}, {16'd0, exp_data});
    check("out_col", {29'd0, out_col}, {29'd0, exp_col});
  endtask

  // Test-plan stream: in_data=n, lb_rdata=n-8 valid for n>=8.
  // Window {n-1, n-9, n, n-8} sums to 4n-18: truncated n-5, rounded n-4.
  task automatic pix(input int n);
    logic [15:0] win;
`ifdef BOX2X2_FILTER_ROUND_EN
    win = 16'(n - 4);
`else
    win = 16'(n - 5);
`endif
    beat(1'b1, 16'(n), n >= 8, (n >= 8) ? 16'(n - 8) : 16'd0, win);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETN = 1'b0;
    in_wen = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_col", {29'd0, out_col}, 32'd0);
    col_m    = 0;
    lbv_m    = 1'b0;
    exp_data = '0;
    exp_col  = '0;
    @(negedge CLK);
    RESETN = 1'b1;
  endtask

  initial begin
    RESETN   = 1'b0;
    in_wen   = 1'b0;
    in_data  = '0;
    lb_rdata = '0;
    lb_valid = 1'b0;
    col_m    = 0;
    lbv_m    = 1'b0;
    exp_data = '0;
    exp_col  = '0;
    #12;
    check("init_out_valid", {31'd0, out_valid}, 32'd0);
    check("init_out_data", {16'd0, out_data}, 32'd0);
    check("init_out_col", {29'd0, out_col}, 32'd0);
    do_reset();

    // First line, then first window at n=9 (column 1)
    for (int n = 0; n <= 9; n++) pix(n);
    check("n9_data", {16'd0, out_data}, {16'd0, EXP9});
    check("n9_col", {29'd0, out_col}, 32'd1);

    // n=16 is column 0 (no pulse), n=17 fires at column 1
    for (int n = 10; n <= 16; n++) pix(n);
    check("n16_no_valid", {31'd0, out_valid}, 32'd0);
    pix(17);
    check("n17_data", {16'd0, out_data}, {16'd0, EXP17});
    check("n17_col", {29'd0, out_col}, 32'd1);

    // 3-cycle stall between n=20 and n=21 is transparent
    for (int n = 18; n <= 20; n++) pix(n);
    for (int s = 0; s < 3; s++) beat(1'b0, 16'hDEAD, 1'b1, 16'hBEEF, 16'h0);
    pix(21);
    check("n21_data", {16'd0, out_data}, {16'd0, EXP21});
    check("n21_col", {29'd0, out_col}, 32'd5);

    // Reset mid-stream at n=19: first beat after release is column 0
    do_reset();
    for (int n = 0; n <= 18; n++) pix(n);
    do_reset();
    pix(19);
    check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    pix(20);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_col", {29'd0, out_col}, 32'd1);
    for (int n = 21; n <= 28; n++) pix(n);

    // Saturation: all 0xFFFF gives 0xFFFF in either mode
    do_reset();
    for (int k = 0; k < 10; k++) beat(1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF);
    check("sat_data", {16'd0, out_data}, 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/box2x2_filter.md
# box2x2_filter

- Streaming 2×2 box-filter stage, directly downstream of the line-buffer memory.
- Takes the current pixel of the input stream and the one-line-delayed pixel from the line buffer, and keeps one column of history for each.
- Emits the truncated (or rounded) mean of each complete 2×2 window.
- Sits between the line buffer and the next pixel-stream consumer; outputs are fully registered.

## Interface
- `WIDTH`, default 8: pixels per line. Must equal the line buffer's delay depth. Integer ≥ 2.
- `DW`, default 16: pixel data width.
- `CLK` input 1: clock, all state updates on the rising edge.
- `RESETN` input 1: reset, asynchronous, active-low.
- `in_data` input DW: current-row pixel, the same value written to the line buffer this cycle.
- `in_wen` input 1: `in_data` is valid this cycle; advances the stream.
- `lb_rdata` input DW: previous-row pixel from the line buffer, aligned with `in_data`.
- `lb_valid` input 1: `lb_rdata` is meaningful this cycle.
- `out_data` output DW: filtered pixel.
- `out_valid` output 1: `out_data` was updated by a window this cycle; one-cycle pulse per result.
- `out_col` output clog2(WIDTH): column index of the window's right-hand pixel.

## Operation
- State:
  - `col` counter, 0..WIDTH-1.
  - `cur_d` (DW): previous current-row pixel.
  - `lb_d` (DW): previous line-buffer pixel.
  - `lbv_d` (1): `lb_valid` captured with `lb_d`.
  - Output registers `out_data`, `out_valid`, `out_col`.
- On a cycle with `in_wen`=1:
  - Window = {`cur_d`, `lb_d`, `in_data`, `lb_rdata`}.
  - Sum = zero-extended sum of the four values, DW+2 bits wide; no overflow possible.
  - Window fire condition: `lb_valid` & `lbv_d` & (`col` ≠ 0).
  - On fire: `out_data` ← sum[DW+1:2] (sum >> 2), `out_col` ← `col`, `out_valid` ← 1.
  - If not fired: `out_valid` ← 0; `out_data` and `out_col` hold.
  - Always: `cur_d` ← `in_data`, `lb_d` ← `lb_rdata`, `lbv_d` ← `lb_valid`.
  - `col` ← `col`+1, or 0 when `col` = WIDTH-1. Wrap is explicit, not power-of-two overflow.
- On a cycle with `in_wen`=0:
  - `out_valid` ← 0.
  - All other state holds. Stalls of any length are transparent to window contents.
- Column 0 never fires: `cur_d`/`lb_d` then hold the last pixel of the prior line, which is not spatially adjacent.
- While `lb_valid`=0, `lb_rdata` is ignored for output purposes. It is still captured into `lb_d`; `lbv_d` masks it on the next window.
- When `lb_valid` deasserts mid-line, firing stops from that pixel onward. Firing resumes two `in_wen` beats after `lb_valid` reasserts, provided `col` ≠ 0.

## Timing
- Latency: 1 cycle from the `in_wen` beat to `out_valid`/`out_data`.
- Throughput: one result per `in_wen` beat. No backpressure; the consumer must accept every `out_valid` pulse.
- Reset (`RESETN`=0, asynchronous): `out_data`=0, `out_valid`=0, `out_col`=0, `col`=0, `cur_d`=0, `lb_d`=0, `lbv_d`=0.
- Reset asserted mid-line: all state clears immediately, and any in-flight `out_valid` is dropped.
- Release is synchronous to the next `CLK` edge. The first beat after release is treated as column 0.
- The upstream line buffer must be reset by the same `RESETN` so column alignment is preserved.
- `lb_valid`/`lb_rdata` must be stable and aligned with `in_data` in the same cycle. No internal skew compensation.

## Configuration
- Macro: `BOX2X2_FILTER_ROUND_EN`.
- Defined: `out_data` ← (sum + 2) >> 2, i.e. round-half-up.
  - The adder is widened so the +2 never wraps; maximum (4·(2^DW−1)+2) still fits DW+2 bits.
- Undefined: `out_data` ← sum >> 2 (truncate). No extra adder.

## Test plan
Stimulus for all scenarios unless stated: WIDTH=8, DW=16. Stream `in_data`=n for n=0,1,2,… with `in_wen`=1 every cycle. `lb_rdata`=n−8 and `lb_valid`=1 for n≥8, else `lb_valid`=0.

1. Truncate mode: first `out_valid` is the cycle after n=9. Window sum is 9+8+1+0=18, so `out_data`=4 and `out_col`=1.
2. Truncate mode: at n=17 the sum is 17+16+9+8=50, so `out_data`=12 and `out_col`=1. No `out_valid` pulse follows n=16 (column 0).
3. `BOX2X2_FILTER_ROUND_EN` defined: at n=17 `out_data`=13. At n=9 `out_data`=5.
4. Insert `in_wen`=0 for 3 cycles between n=20 and n=21: `out_valid`=0 for those 3 cycles. The next result is still (21+20+13+12)>>2=16.
5. Saturation: all inputs 0xFFFF with both valids high. In steady state `out_data`=0xFFFF in both modes; no wrap.
6. Drop `RESETN` at n=19 for 1 cycle: outputs are 0 immediately. After release, the first beat is column 0, and no `out_valid` occurs until the second beat with `lb_valid`=1.
